mc_core: RTL

Multi-cycle RV32I-subset core that follows on from the single-cycle datapath. It runs one instruction over 3–5 cycles through a decode/execute FSM. One ALU and a single unified memory port are shared across states, and every memory access is gated by a valid/ready handshake. The block contains the PC, IR, register file, ALU and control. It sits between the SoC top and one memory slave, so instruction and data memory no longer need separate, zero-latency arrays.

---
 rtl/mc_core.sv | 271 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/mc_core.sv
// rtl/mc_core.sv - multi-cycle RV32I-subset core with one shared memory port
// Optional feature macro: MCORE_INSTRET_EN (retired-instruction counter on instret).
module mc_core #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          NREGS    = 32
) (
  input  logic        clk,
  input  logic        reset,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic [31:0] pc_o,
  output logic        retire,
  output logic        halted,
  output logic [31:0] instret
);

  localparam int RW = $clog2(NREGS);

  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d, ir_q, ir_d;
  logic [31:0] a_q, a_d, b_q, b_d, imm_q, imm_d, tgt_q, tgt_d, res_q, res_d;
  logic        req_q, req_d, we_q, we_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d;
  logic [31:0] rf_q [NREGS];

  logic          rf_we;
  logic [31:0]   rf_wdata, rd1, rd2, pc_plus4;
  logic [6:0]    opcode, funct7;
  logic [2:0]    funct3;
  logic [RW-1:0] rd_idx, rs1_idx, rs2_idx;
  logic          is_r, is_alui, is_lw, is_sw, is_br, is_jal, legal, taken;
  logic [31:0]   imm_i, imm_s, imm_b, imm_j, imm_sel;
  logic [31:0]   alu_b, alu_y;
  logic          do_fetch;
  logic [31:0]   fetch_pc;

  assign opcode  = ir_q[6:0];
  assign funct3  = ir_q[14:12];
  assign funct7  = ir_q[31:25];
  assign rd_idx  = ir_q[7 +: RW];
  assign rs1_idx = ir_q[15 +: RW];
  assign rs2_idx = ir_q[20 +: RW];

  assign imm_i = {{20{ir_q[31]}}, ir_q[31:20]};
  assign imm_s = {{20{ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
  assign imm_b = {{19{ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
  assign imm_j = {{11{ir_q[31]}}, ir_q[31], ir_q[19:12], ir_q[20], ir_q[30:21], 1'b0};

  // x0 is never written, but gate the read anyway so it is 0 by construction
  assign rd1 = (rs1_idx == '0) ? 32'h0 : rf_q[rs1_idx];
  assign rd2 = (rs2_idx == '0) ? 32'h0 : rf_q[rs2_idx];

  assign pc_plus4 = pc_q + 32'd4;
  assign taken    = (a_q == b_q) ^ funct3[0];
  assign rf_wdata = is_jal ? pc_plus4 : res_q;

  // instruction class, legality and immediate selection from the IR
  always_comb begin
    is_r    = (opcode == 7'h33);
    is_alui = (opcode == 7'h13);
    is_lw   = (opcode == 7'h03);
    is_sw   = (opcode == 7'h23);
    is_br   = (opcode == 7'h63);
    is_jal  = (opcode == 7'h6F);
    legal   = 1'b0;
    case (opcode)
      7'h33: legal = ((funct7 == 7'h00) && (funct3 == 3'b000 || funct3 == 3'b111 ||
                                            funct3 == 3'b110 || funct3 == 3'b010)) ||
                     ((funct7 == 7'h20) && (funct3 == 3'b000));
      7'h13: legal = (funct3 == 3'b000 || funct3 == 3'b111 ||
                      funct3 == 3'b110 || funct3 == 3'b010);
      7'h03: legal = (funct3 == 3'b010);
      7'h23: legal = (funct3 == 3'b010);
      7'h63: legal = (funct3 == 3'b000 || funct3 == 3'b001);
      7'h6F: legal = 1'b1;
      default: legal = 1'b0;
    endcase
    case (opcode)
      7'h23:   imm_sel = imm_s;
      7'h63:   imm_sel = imm_b;
      7'h6F:   imm_sel = imm_j;
      default: imm_sel = imm_i;
    endcase
  end

  // shared ALU; loads and stores always use it as an address adder
  always_comb begin
    alu_b = is_r ? b_q : imm_q;
    alu_y = a_q + alu_b;
    if (!(is_lw || is_sw)) begin
      case (funct3)
        3'b000:  alu_y = (is_r && funct7[5]) ? (a_q - alu_b) : (a_q + alu_b);
        3'b111:  alu_y = a_q & alu_b;
        3'b110:  alu_y = a_q | alu_b;
        3'b010:  alu_y = {31'b0, $signed(a_q) < $signed(alu_b)};
        default: alu_y = a_q + alu_b;
      endcase
    end
  end

  // next-state, datapath latches and registered memory request
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    a_d      = a_q;
    b_d      = b_q;
    imm_d    = imm_q;
    tgt_d    = tgt_q;
    res_d    = res_q;
    req_d    = req_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    retire   = 1'b0;
    rf_we    = 1'b0;
    do_fetch = 1'b0;
    fetch_pc = pc_plus4;
    case (state_q)
      S_FETCH: begin
        if (pc_q[1:0] != 2'b00) begin
          state_d = S_HALT;
          req_d   = 1'b0;
        end else if (!req_q) begin
          // first fetch after reset: raise the request for the next cycle
          req_d  = 1'b1;
          we_d   = 1'b0;
          addr_d = pc_q;
        end else if (mem_ready) begin
          ir_d    = mem_rdata;
          req_d   = 1'b0;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        a_d   = rd1;
        b_d   = rd2;
        imm_d = imm_sel;
        tgt_d = (pc_q + imm_sel) & ~32'd1;
        if (!legal)      state_d = S_HALT;
        else if (is_jal) state_d = S_WB;
        else             state_d = S_EXEC;
      end
      S_EXEC: begin
        res_d = alu_y;
        if (is_br) begin
          retire   = 1'b1;
          pc_d     = taken ? tgt_q : pc_plus4;
          state_d  = S_FETCH;
          do_fetch = 1'b1;
          fetch_pc = pc_d;
        end else if (is_lw || is_sw) begin
          if (alu_y[1:0] != 2'b00) begin
            state_d = S_HALT;
          end else begin
            state_d = S_MEM;
            req_d   = 1'b1;
            we_d    = is_sw;
            addr_d  = alu_y;
            wdata_d = b_q;
          end
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        if (mem_ready) begin
          if (is_sw) begin
            retire   = 1'b1;
            pc_d     = pc_plus4;
            state_d  = S_FETCH;
            do_fetch = 1'b1;
            fetch_pc = pc_plus4;
          end else begin
            res_d   = mem_rdata;
            req_d   = 1'b0;
            we_d    = 1'b0;
            state_d = S_WB;
          end
        end
      end
      S_WB: begin
        retire   = 1'b1;
        rf_we    = (rd_idx != '0);
        pc_d     = is_jal ? tgt_q : pc_plus4;
        state_d  = S_FETCH;
        do_fetch = 1'b1;
        fetch_pc = pc_d;
      end
      S_HALT: begin
        req_d = 1'b0;
        we_d  = 1'b0;
      end
      default: state_d = S_HALT;
    endcase
    // a misaligned next PC never reaches the bus; FETCH turns it into a trap
    if (do_fetch) begin
      req_d = (fetch_pc[1:0] == 2'b00);
      we_d  = 1'b0;
      if (fetch_pc[1:0] == 2'b00) addr_d = fetch_pc;
    end
  end

  // state and datapath registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_FETCH;
      pc_q    <= RESET_PC;
      ir_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      imm_q   <= '0;
      tgt_q   <= '0;
      res_q   <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      a_q     <= a_d;
      b_q     <= b_d;
      imm_q   <= imm_d;
      tgt_q   <= tgt_d;
      res_q   <= res_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  // register file, cleared on reset and written only from WB
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREGS; i++) rf_q[i] <= '0;
    end else if (rf_we) begin
      rf_q[rd_idx] <= rf_wdata;
    end
  end

  assign mem_req   = req_q;
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign pc_o      = pc_q;
  assign halted    = (state_q == S_HALT);

`ifdef MCORE_INSTRET_EN
  logic [31:0] instret_q;

  // retired-instruction counter, wraps naturally at 32 bits
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                           instret_q <= '0;
    else if (retire && state_q != S_HALT) instret_q <= instret_q + 32'd1;
  end

  assign instret = instret_q;
`else
  assign instret = 32'h0;
`endif

endmodule
